// File: rtl/mem_request_initiator_if.sv
// NOC packet format and the client/NOC signal bundle of the memory request initiator.
package mem_noc_pkg;
    localparam int PKT_ID_W = 8;

    typedef enum logic [3:0] {
        pt_none              = 4'd0,
        memory_read_request  = 4'd1,
        memory_write_request = 4'd2,
        memory_read_reply    = 4'd3,
        memory_write_reply   = 4'd4
    } packet_type_t;

    typedef struct packed {
        packet_type_t          pt;
        logic [PKT_ID_W-1:0]   id;
        logic [3:0]            dst_addr;
        logic [3:0]            dst_prt;
        logic [3:0]            src_addr;
        logic [3:0]            src_prt;
        logic [127:0]          dat;
    } packet_t;
endpackage

// Client request/response handshake plus the NOC stop tx/rx handshake.
// master = client / NOC stop side, slave = the initiator.
interface mem_request_initiator_if;
    import mem_noc_pkg::*;

    logic          req_valid;
    logic          req_we;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          req_ready;

    logic          rsp_valid;
    logic          rsp_we;
    logic          rsp_err;
    logic [127:0]  rsp_rdata;

    packet_t       dat_to_noc;
    logic          tx_submit;
    logic          tx_complete;

    packet_t       dat_from_noc;
    logic          rx_recieve;
    logic          rx_complete;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_we, rsp_err, rsp_rdata,
        output dat_to_noc, tx_submit,
        input  tx_complete,
        input  dat_from_noc, rx_recieve,
        output rx_complete
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_we, rsp_err, rsp_rdata,
        input  dat_to_noc, tx_submit,
        output tx_complete,
        output dat_from_noc, rx_recieve,
        input  rx_complete
    );
endinterface

// File: rtl/mem_request_initiator.sv
// One-outstanding-request memory client on a NOC stop: builds a read/write
// request packet, waits for the tagged reply (dropping anything else), and
// returns data, write completion or a timeout error to the client.
module mem_request_initiator
    import mem_noc_pkg::*;
#(
    parameter logic [3:0] MEM_ADDR = 4'd1,
    parameter logic [3:0] MEM_PRT  = 4'd2,
    parameter int         ID_W     = 8,
    parameter int         TIMEOUT  = 1024
) (
    input  logic       fclk,
    input  logic       rst,
    input  logic [3:0] port_address,
    input  logic [3:0] port_number,
    output logic [7:0] drop_count,
    mem_request_initiator_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RPL, RESP} state_t;

    state_t          state;
    logic [ID_W-1:0] cur_id;
    logic [TW-1:0]   timer;
    logic            lat_we;
    logic            rx_guard;

    logic            rx_seen;
    logic            rx_match;
    logic            tmo_hit;
    logic            unused_rx;

    // A pending packet is only looked at when it is not the one being retired:
    // blocked during the rx_complete pulse and the cycle after it.
    assign rx_seen  = bus.rx_recieve && !bus.rx_complete && !rx_guard;
    assign rx_match = rx_seen
                   && bus.dat_from_noc.pt == (lat_we ? memory_write_reply : memory_read_reply)
                   && bus.dat_from_noc.id == PKT_ID_W'(cur_id);
    // Fires on the no-match cycle where the timer steps onto TIMEOUT-1.
    assign tmo_hit  = (timer + TW'(1)) == TW'(TIMEOUT - 1);

    // Routing fields of replies are already resolved by the NOC stop.
    assign unused_rx = ^{bus.dat_from_noc.dst_addr, bus.dat_from_noc.dst_prt,
                         bus.dat_from_noc.src_addr, bus.dat_from_noc.src_prt};

    // Transaction FSM; every output is registered here.
    always_ff @(posedge fclk) begin
        if (!rst) begin
            state           <= IDLE;
            cur_id          <= '0;
            timer           <= '0;
            lat_we          <= 1'b0;
            rx_guard        <= 1'b0;
            drop_count      <= 8'd0;
            bus.req_ready   <= 1'b1;
            bus.tx_submit   <= 1'b0;
            bus.rx_complete <= 1'b0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_we      <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.dat_to_noc  <= '0;
        end else begin
            bus.rx_complete <= 1'b0;
            rx_guard        <= bus.rx_complete;
            case (state)
                IDLE: begin
                    if (bus.rsp_valid) begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                    end else if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready           <= 1'b0;
                        lat_we                  <= bus.req_we;
                        bus.dat_to_noc.pt       <= bus.req_we ? memory_write_request
                                                              : memory_read_request;
                        bus.dat_to_noc.id       <= PKT_ID_W'(cur_id);
                        bus.dat_to_noc.dst_addr <= MEM_ADDR;
                        bus.dat_to_noc.dst_prt  <= MEM_PRT;
                        bus.dat_to_noc.src_addr <= port_address;
                        bus.dat_to_noc.src_prt  <= port_number;
                        bus.dat_to_noc.dat      <= {64'd0,
                                                    bus.req_we ? bus.req_wdata : 32'd0,
                                                    bus.req_addr};
                        bus.tx_submit           <= 1'b1;
                        state                   <= SEND;
                    end
                end
                SEND: begin
                    if (bus.tx_complete) begin
                        bus.tx_submit <= 1'b0;
                        timer         <= '0;
                        state         <= WAIT_RPL;
                    end
                end
                WAIT_RPL: begin
                    if (rx_match) begin
                        bus.rx_complete <= 1'b1;
                        bus.rsp_rdata   <= lat_we ? 128'd0 : bus.dat_from_noc.dat;
                        bus.rsp_err     <= 1'b0;
                        state           <= RESP;
                    end else begin
                        timer <= timer + TW'(1);
                        if (rx_seen) begin
                            bus.rx_complete <= 1'b1;
                            if (drop_count != 8'hFF)
                                drop_count <= drop_count + 8'd1;
                        end
                        if (tmo_hit) begin
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= '0;
                            state         <= RESP;
                        end
                    end
                end
                RESP: begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_we    <= lat_we;
                    cur_id        <= cur_id + 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_request_initiator.sv
// Randomized bench: a queue-based NOC stop model feeds replies, and every
// transaction is checked against the expected packet, response and timing.
module tb_mem_request_initiator;
    import mem_noc_pkg::*;

    localparam int         ID_W     = 3;
    localparam int         TIMEOUT  = 16;
    localparam int         ID_MOD   = 1 << ID_W;
    localparam logic [3:0] MEM_ADDR = 4'd1;
    localparam logic [3:0] MEM_PRT  = 4'd2;
    localparam logic [3:0] MY_ADDR  = 4'd6;
    localparam logic [3:0] MY_PRT   = 4'd3;

    logic       fclk = 1'b0;
    logic       rst  = 1'b0;
    logic [7:0] drop_count;

    mem_request_initiator_if bus();

    mem_request_initiator #(
        .MEM_ADDR(MEM_ADDR), .MEM_PRT(MEM_PRT), .ID_W(ID_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .fclk(fclk),
        .rst(rst),
        .port_address(MY_ADDR),
        .port_number(MY_PRT),
        .drop_count(drop_count),
        .bus(bus)
    );

    always #5 fclk = ~fclk;

    int n_cmp = 0;
    int n_err = 0;
    int exp_id = 0;
    int exp_drop = 0;
    int rxc_cnt = 0;
    int rsp_cnt = 0;
    packet_t rxq[$];

    // NOC stop rx side: retire the head packet on rx_complete, then present the next.
    always begin
        @(negedge fclk);
        if (bus.rx_complete && rxq.size() != 0) void'(rxq.pop_front());
        #1;
        bus.rx_recieve   = (rxq.size() != 0);
        bus.dat_from_noc = (rxq.size() != 0) ? rxq[0] : '0;
    end

    // Pulse counters for rx_complete and rsp_valid.
    always @(posedge fclk) begin
        if (bus.rx_complete) rxc_cnt <= rxc_cnt + 1;
        if (bus.rsp_valid)   rsp_cnt <= rsp_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic packet_t exp_req(input bit we, input logic [31:0] a,
                                        input logic [31:0] d, input int id);
        packet_t p = '0;
        p.pt       = we ? memory_write_request : memory_read_request;
        p.id       = 8'(id);
        p.dst_addr = MEM_ADDR;
        p.dst_prt  = MEM_PRT;
        p.src_addr = MY_ADDR;
        p.src_prt  = MY_PRT;
        p.dat[31:0] = a;
        if (we) p.dat[63:32] = d;
        return p;
    endfunction

    function automatic packet_t mk_reply(input bit we, input int id, input logic [127:0] d);
        packet_t p = '0;
        p.pt       = we ? memory_write_reply : memory_read_reply;
        p.id       = 8'(id);
        p.dst_addr = MY_ADDR;
        p.dst_prt  = MY_PRT;
        p.src_addr = MEM_ADDR;
        p.src_prt  = MEM_PRT;
        p.dat      = d;
        return p;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One client transaction. Stale packets precede the real reply; bit i of
    // kinds picks a wrong-type reply (1) or a previous-id reply (0).
    task automatic txn(input bit we, input logic [31:0] a, input logic [31:0] d,
                       input logic [127:0] rd, input int tx_dly, input int nstale,
                       input int kinds, input bit reply);
        packet_t ep;
        int c;
        int rxc0;
        ep = exp_req(we, a, d, exp_id);
        c = 0;
        while (!bus.req_ready && c < 50) begin @(negedge fclk); c++; end
        check("req_ready_idle", 160'(bus.req_ready), 160'(1));
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d;
        @(negedge fclk);
        bus.req_valid = 1'b0; bus.req_we = 1'($urandom);
        bus.req_addr = $urandom; bus.req_wdata = $urandom;
        check("tx_submit", 160'(bus.tx_submit), 160'(1));
        check("req_ready_busy", 160'(bus.req_ready), 160'(0));
        check("req_pkt", 160'(bus.dat_to_noc), 160'(ep));
        for (int i = 0; i < tx_dly; i++) begin
            @(negedge fclk);
            check("tx_hold", 160'(bus.tx_submit), 160'(1));
            check("pkt_stable", 160'(bus.dat_to_noc), 160'(ep));
        end
        rxc0 = rxc_cnt;
        for (int i = 0; i < nstale; i++) begin
            if ((kinds >> i) & 1) rxq.push_back(mk_reply(!we, exp_id, rnd128()));
            else rxq.push_back(mk_reply(we, (exp_id + ID_MOD - 1) % ID_MOD, rnd128()));
        end
        if (reply) rxq.push_back(mk_reply(we, exp_id, rd));
        bus.tx_complete = 1'b1;
        @(negedge fclk);
        bus.tx_complete = 1'b0;
        check("tx_release", 160'(bus.tx_submit), 160'(0));
        c = 0;
        while (!bus.rsp_valid && c < 60) begin @(negedge fclk); c++; end
        check("rsp_valid", 160'(bus.rsp_valid), 160'(1));
        check("rsp_latency", 160'(c), 160'(reply ? 3 * nstale + 2 : TIMEOUT));
        check("rsp_we", 160'(bus.rsp_we), 160'(we));
        check("rsp_err", 160'(bus.rsp_err), 160'(!reply));
        check("rsp_rdata", 160'(bus.rsp_rdata), 160'((reply && !we) ? rd : 128'd0));
        check("ready_in_rsp", 160'(bus.req_ready), 160'(0));
        exp_drop = (exp_drop + nstale > 255) ? 255 : exp_drop + nstale;
        check("drop_count", 160'(drop_count), 160'(exp_drop));
        check("rx_pulses", 160'(rxc_cnt - rxc0), 160'(nstale + int'(reply)));
        @(negedge fclk);
        check("rsp_one_cycle", 160'(bus.rsp_valid), 160'(0));
        check("ready_back", 160'(bus.req_ready), 160'(1));
        exp_id = (exp_id + 1) % ID_MOD;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"},  160'(bus.req_ready),   160'(1));
        check({tag, "_submit"}, 160'(bus.tx_submit),   160'(0));
        check({tag, "_rxc"},    160'(bus.rx_complete), 160'(0));
        check({tag, "_rspv"},   160'(bus.rsp_valid),   160'(0));
        check({tag, "_err"},    160'(bus.rsp_err),     160'(0));
        check({tag, "_we"},     160'(bus.rsp_we),      160'(0));
        check({tag, "_rdata"},  160'(bus.rsp_rdata),   160'(0));
        check({tag, "_pkt"},    160'(bus.dat_to_noc),  160'(0));
        check({tag, "_drops"},  160'(drop_count),      160'(0));
    endtask

    initial begin
        int r0;
        bit we;
        bit rep;
        int ns;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.tx_complete = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge fclk);
        check_reset_state("reset");
        rst = 1'b1;

        // directed: read, write, then ids 2..4
        txn(1'b0, 32'h40, 32'h0, 128'h0123456789ABCDEF0123456789ABCDEF, 0, 0, 0, 1'b1);
        txn(1'b1, 32'h80, 32'hDEADBEEF, rnd128(), 0, 0, 0, 1'b1);
        for (int i = 0; i < 3; i++) txn(1'b0, $urandom, $urandom, rnd128(), 1, 0, 0, 1'b1);
        // id 5 write: old id 4 reply, then read reply with id 5, then the real one
        txn(1'b1, $urandom, $urandom, rnd128(), 0, 2, 2, 1'b1);
        // id 6 times out; its late reply is dropped during id 7
        txn(1'b0, $urandom, $urandom, rnd128(), 0, 0, 0, 1'b0);
        txn(1'b0, $urandom, $urandom, rnd128(), 0, 1, 0, 1'b1);
        // id wraps to 0; NOC backpressure for 10 cycles
        txn(1'b1, $urandom, $urandom, rnd128(), 10, 0, 0, 1'b1);

        // reset in the middle of SEND with a packet pending on rx
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h100;
        @(negedge fclk);
        bus.req_valid = 1'b0;
        check("mid_submit", 160'(bus.tx_submit), 160'(1));
        rxq.push_back(mk_reply(1'b0, 3, rnd128()));
        repeat (3) @(negedge fclk);
        r0 = rsp_cnt;
        rst = 1'b0;
        @(negedge fclk);
        rst = 1'b1;
        check_reset_state("midrst");
        check("midrst_rx_kept", 160'(rxq.size()), 160'(1));
        repeat (6) @(negedge fclk);
        check("midrst_no_rsp", 160'(rsp_cnt - r0), 160'(0));
        check("midrst_idle", 160'(bus.tx_submit), 160'(0));
        rxq.delete();
        exp_id = 0;
        exp_drop = 0;
        @(negedge fclk);

        // randomized traffic, wrapping ids several times
        for (int i = 0; i < 24; i++) begin
            we  = 1'($urandom);
            rep = ($urandom_range(0, 7) != 0);
            ns  = rep ? int'($urandom_range(0, 2)) : 0;
            txn(we, $urandom, $urandom, rnd128(), int'($urandom_range(0, 3)), ns,
                int'($urandom_range(0, 3)), rep);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
